// File: rtl/rob_store_commit_ctrl.sv
// rob_store_commit_ctrl
//   Retires the store at the ROB head. The block latches the head store, requests the
//   data-memory port, waits for the write response and retries after a NACK or a response
//   timeout, with a backoff between attempts. st_commit pulses for one cycle when the write
//   is done. The ROB may retire a head store only on that pulse. When the retries run out,
//   the block parks in a sticky error state that only reset clears.
//
// Ports
//   clock, reset     system clock; synchronous active-high reset
//   head_st_valid    head of ROB is a completed store (sampled only when idle)
//   head_st_tag      Tnew tag of the head store
//   st_addr/st_data  store address/data from the LSQ
//   mem_gnt          memory port accepts mem_req
//   mem_resp_valid   write response for the outstanding store
//   mem_resp_ok      1 = write done, 0 = NACK
//   mem_req          store request to the memory port
//   mem_addr/data    latched store address/data
//   st_commit        one-cycle retire pulse
//   st_commit_tag    tag of the committed store, valid with st_commit
//   st_busy          a store is in flight
//   st_error         sticky: retries exhausted
module rob_store_commit_ctrl #(
    parameter int unsigned TAG_W        = 6,
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned MAX_RETRY    = 4,
    parameter int unsigned BACKOFF      = 3,
    parameter int unsigned RESP_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              head_st_valid,
    input  logic [TAG_W-1:0]  head_st_tag,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              mem_gnt,
    input  logic              mem_resp_valid,
    input  logic              mem_resp_ok,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              st_commit,
    output logic [TAG_W-1:0]  st_commit_tag,
    output logic              st_busy,
    output logic              st_error
);

    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TW = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
    localparam int unsigned BW = (BACKOFF > 0) ? $clog2(BACKOFF + 1) : 1;

    localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);
    localparam logic [TW-1:0] ToMax    = TW'(RESP_TIMEOUT);
    localparam logic [BW-1:0] BoInit   = BW'(BACKOFF);
    localparam logic [BW-1:0] BoLast   = BW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StBackoff,
        StCommit,
        StError
    } state_e;

    state_e             state_q, state_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [TW-1:0]      to_q, to_d;
    logic [BW-1:0]      bo_q, bo_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            retry_q <= '0;
            to_q    <= '0;
            bo_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            to_q    <= to_d;
            bo_q    <= bo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        to_d    = to_q;
        bo_d    = bo_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tag_d   = tag_q;

        case (state_q)
            StIdle: begin
                if (head_st_valid) begin
                    addr_d  = st_addr;
                    data_d  = st_data;
                    tag_d   = head_st_tag;
                    retry_d = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    to_d    = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // A response in the timeout cycle takes priority over the timeout.
                if (mem_resp_valid && mem_resp_ok) begin
                    state_d = StCommit;
                end else if (mem_resp_valid || (to_q == ToMax)) begin
                    if (retry_q == RetryMax) begin
                        state_d = StError;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        bo_d    = BoInit;
                        state_d = StBackoff;
                    end
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            StBackoff: begin
                // The counter reaches zero as the state returns to REQ, so BACKOFF idle cycles
                // separate the failure from the re-request.
                if (bo_q <= BoLast) begin
                    bo_d    = '0;
                    state_d = StReq;
                end else begin
                    bo_d = bo_q - BW'(1);
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_req       = (state_q == StReq);
    assign mem_addr      = addr_q;
    assign mem_data      = data_q;
    assign st_commit     = (state_q == StCommit);
    assign st_commit_tag = (state_q == StCommit) ? tag_q : '0;
    assign st_busy       = (state_q != StIdle);
    assign st_error      = (state_q == StError);

endmodule

// File: tb/tb_rob_store_commit_ctrl.sv
// Bench for rob_store_commit_ctrl. Each store transaction is described by a plan of
// memory attempts (grant delay, response kind, response delay). A timeline model turns the
// plan into the cycles where mem_req, st_commit, st_busy and st_error must be high. The
// driver applies the plan and, optionally, random stray inputs that the block must ignore.
module tb_rob_store_commit_ctrl;

    localparam int TAG_W        = 6;
    localparam int ADDR_W       = 64;
    localparam int DATA_W       = 64;
    localparam int MAX_RETRY    = 4;
    localparam int BACKOFF      = 3;
    localparam int RESP_TIMEOUT = 15;
    localparam int MAXC         = 512;
    localparam int KOk          = 0;
    localparam int KNack        = 1;
    localparam int KTo          = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              head_st_valid = 1'b0;
    logic [TAG_W-1:0]  head_st_tag = '0;
    logic [ADDR_W-1:0] st_addr = '0;
    logic [DATA_W-1:0] st_data = '0;
    logic              mem_gnt = 1'b0;
    logic              mem_resp_valid = 1'b0;
    logic              mem_resp_ok = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              st_commit;
    logic [TAG_W-1:0]  st_commit_tag;
    logic              st_busy;
    logic              st_error;

    int vectors = 0;
    int miscompares = 0;

    // Plan of one transaction
    int                p_g[8];
    int                p_kind[8];
    int                p_r[8];
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_data;
    logic [TAG_W-1:0]  p_tag;
    bit                p_stray;
    int                p_extra;

    // Timeline model results, cycle 0 = cycle head_st_valid is offered
    int         req_lo[8], req_hi[8], wait_lo[8], wait_hi[8];
    int         n_used, commit_at, err_at, n_cyc;
    logic [3:0] exp_flags[MAXC];   // {mem_req, st_commit, st_busy, st_error}

    logic [3:0]        obs_flags[MAXC];
    logic [ADDR_W-1:0] obs_addr[MAXC];
    logic [DATA_W-1:0] obs_data[MAXC];
    logic [TAG_W-1:0]  obs_tag[MAXC];

    rob_store_commit_ctrl #(
        .TAG_W        (TAG_W),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_RETRY    (MAX_RETRY),
        .BACKOFF      (BACKOFF),
        .RESP_TIMEOUT (RESP_TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .head_st_valid  (head_st_valid),
        .head_st_tag    (head_st_tag),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .mem_gnt        (mem_gnt),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ok    (mem_resp_ok),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .st_commit      (st_commit),
        .st_commit_tag  (st_commit_tag),
        .st_busy        (st_busy),
        .st_error       (st_error)
    );

    always #5 clock = ~clock;

    function automatic void build_model();
        int t;
        int fails;
        logic rq;
        t = 1;
        fails = 0;
        commit_at = -1;
        err_at = -1;
        n_used = 0;
        for (int i = 0; i < 8; i++) begin
            req_lo[i]  = t;
            req_hi[i]  = t + p_g[i];
            wait_lo[i] = req_hi[i] + 1;
            wait_hi[i] = (p_kind[i] == KTo) ? wait_lo[i] + RESP_TIMEOUT : wait_lo[i] + p_r[i];
            n_used = i + 1;
            if (p_kind[i] == KOk) begin
                commit_at = wait_hi[i] + 1;
                break;
            end
            fails++;
            if (fails == MAX_RETRY + 1) begin
                err_at = wait_hi[i] + 1;
                break;
            end
            t = wait_hi[i] + BACKOFF + 1;
        end
        n_cyc = (commit_at >= 0) ? commit_at + 1 + p_extra : err_at + 1 + p_extra;
        for (int n = 0; n < n_cyc; n++) begin
            rq = 1'b0;
            for (int i = 0; i < n_used; i++) begin
                if (n >= req_lo[i] && n <= req_hi[i]) rq = 1'b1;
            end
            exp_flags[n] = {rq, n == commit_at, n >= 1 && (commit_at < 0 || n <= commit_at),
                            err_at >= 0 && n >= err_at};
        end
    endfunction

    task automatic idle_inputs();
        head_st_valid  = 1'b0;
        head_st_tag    = '0;
        st_addr        = '0;
        st_data        = '0;
        mem_gnt        = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_ok    = 1'b0;
    endtask

    // Entered one step after a clock edge with the DUT idle; leaves the same way.
    task automatic run_txn();
        build_model();
        for (int n = 0; n < n_cyc; n++) begin
            logic gnt, rv, rok, in_wait;
            gnt = 1'b0;
            rv = 1'b0;
            rok = 1'b0;
            in_wait = 1'b0;
            for (int i = 0; i < n_used; i++) begin
                if (n == req_hi[i]) gnt = 1'b1;
                if (n >= wait_lo[i] && n <= wait_hi[i]) in_wait = 1'b1;
                if (p_kind[i] != KTo && n == wait_hi[i]) begin
                    rv = 1'b1;
                    rok = (p_kind[i] == KOk);
                end
            end
            if (!in_wait && p_stray) begin
                rv = 1'($urandom);
                rok = 1'($urandom);
            end
            if (n == 0) begin
                head_st_valid = 1'b1;
                head_st_tag   = p_tag;
                st_addr       = p_addr;
                st_data       = p_data;
            end else if (p_stray) begin
                head_st_valid = (commit_at < 0 || n <= commit_at) ? 1'($urandom) : 1'b0;
                head_st_tag   = TAG_W'($urandom);
                st_addr       = {$urandom, $urandom};
                st_data       = {$urandom, $urandom};
            end else begin
                head_st_valid = 1'b0;
                head_st_tag   = '0;
                st_addr       = '0;
                st_data       = '0;
            end
            mem_gnt        = gnt;
            mem_resp_valid = rv;
            mem_resp_ok    = rok;
            #2;
            obs_flags[n] = {mem_req, st_commit, st_busy, st_error};
            obs_addr[n]  = mem_addr;
            obs_data[n]  = mem_data;
            obs_tag[n]   = st_commit_tag;
            @(posedge clock);
            #1;
        end
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            head_st_valid  = 1'($urandom);
            head_st_tag    = TAG_W'($urandom);
            st_addr        = {$urandom, $urandom};
            st_data        = {$urandom, $urandom};
            mem_gnt        = 1'($urandom);
            mem_resp_valid = 1'($urandom);
            mem_resp_ok    = 1'($urandom);
            @(posedge clock);
            #1;
            vectors++;
            if ({mem_req, st_commit, st_busy, st_error, mem_addr, mem_data, st_commit_tag} !== '0)
            begin
                miscompares++;
                $display("FAIL reset c%0d outputs req=%b commit=%b busy=%b err=%b addr=%h data=%h tag=%h, want all 0",
                         k, mem_req, st_commit, st_busy, st_error, mem_addr, mem_data, st_commit_tag);
            end
        end
        idle_inputs();
        reset = 1'b0;
        @(posedge clock);
        #1;
        vectors++;
        if ({mem_req, st_commit, st_busy, st_error} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_release flags got %b want 0000",
                     {mem_req, st_commit, st_busy, st_error});
        end
    endtask

    task automatic test_basic();
        p_tag = 6'd7; p_addr = 64'h100; p_data = 64'hAB; p_stray = 1'b0; p_extra = 3;
        p_g[0] = 0; p_kind[0] = KOk; p_r[0] = 0;
        run_txn();
        for (int n = 0; n < n_cyc; n++) begin
            vectors++;
            if (obs_flags[n] !== exp_flags[n]) begin
                miscompares++;
                $display("FAIL basic c%0d req/commit/busy/err got %b want %b", n, obs_flags[n], exp_flags[n]);
            end
            if (exp_flags[n][3] && {obs_addr[n], obs_data[n]} !== {p_addr, p_data}) begin
                miscompares++;
                $display("FAIL basic_addr c%0d got %h/%h want %h/%h", n, obs_addr[n], obs_data[n], p_addr, p_data);
            end
            if (exp_flags[n][2] && obs_tag[n] !== p_tag) begin
                miscompares++;
                $display("FAIL basic_tag c%0d got %0d want %0d", n, obs_tag[n], p_tag);
            end
        end
    endtask

    task automatic test_grant_stall();
        p_tag = TAG_W'($urandom); p_addr = {$urandom, $urandom}; p_data = {$urandom, $urandom};
        p_stray = 1'b0; p_extra = 2;
        p_g[0] = 5; p_kind[0] = KOk; p_r[0] = 0;
        run_txn();
        for (int n = 0; n < n_cyc; n++) begin
            vectors++;
            if (obs_flags[n] !== exp_flags[n]) begin
                miscompares++;
                $display("FAIL grant_stall c%0d flags got %b want %b", n, obs_flags[n], exp_flags[n]);
            end
            if (exp_flags[n][3] && {obs_addr[n], obs_data[n]} !== {p_addr, p_data}) begin
                miscompares++;
                $display("FAIL grant_stall_addr c%0d got %h/%h want %h/%h", n, obs_addr[n], obs_data[n], p_addr, p_data);
            end
            if (exp_flags[n][2] && obs_tag[n] !== p_tag) begin
                miscompares++;
                $display("FAIL grant_stall_tag c%0d got %0d want %0d", n, obs_tag[n], p_tag);
            end
        end
    endtask

    task automatic test_nack_retry();
        p_tag = TAG_W'($urandom); p_addr = {$urandom, $urandom}; p_data = {$urandom, $urandom};
        p_stray = 1'b0; p_extra = 4;
        p_g[0] = 0; p_kind[0] = KNack; p_r[0] = 0;
        p_g[1] = 0; p_kind[1] = KOk;   p_r[1] = 0;
        run_txn();
        for (int n = 0; n < n_cyc; n++) begin
            vectors++;
            if (obs_flags[n] !== exp_flags[n]) begin
                miscompares++;
                $display("FAIL nack_retry c%0d flags got %b want %b", n, obs_flags[n], exp_flags[n]);
            end
            if (exp_flags[n][3] && {obs_addr[n], obs_data[n]} !== {p_addr, p_data}) begin
                miscompares++;
                $display("FAIL nack_retry_addr c%0d got %h/%h want %h/%h", n, obs_addr[n], obs_data[n], p_addr, p_data);
            end
            if (exp_flags[n][2] && obs_tag[n] !== p_tag) begin
                miscompares++;
                $display("FAIL nack_retry_tag c%0d got %0d want %0d", n, obs_tag[n], p_tag);
            end
        end
    endtask

    // Minimum-latency stores offered as soon as the block is idle again: 4 cycles each.
    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            p_tag = TAG_W'($urandom); p_addr = {$urandom, $urandom}; p_data = {$urandom, $urandom};
            p_stray = 1'b0; p_extra = (k == 2) ? 2 : 0;
            p_g[0] = 0; p_kind[0] = KOk; p_r[0] = 0;
            run_txn();
            for (int n = 0; n < n_cyc; n++) begin
                vectors++;
                if (obs_flags[n] !== exp_flags[n]) begin
                    miscompares++;
                    $display("FAIL back_to_back t%0d c%0d flags got %b want %b", k, n, obs_flags[n], exp_flags[n]);
                end
                if (exp_flags[n][2] && obs_tag[n] !== p_tag) begin
                    miscompares++;
                    $display("FAIL back_to_back_tag t%0d c%0d got %0d want %0d", k, n, obs_tag[n], p_tag);
                end
            end
        end
    endtask

    task automatic test_stray_idle();
        for (int k = 0; k < 10; k++) begin
            head_st_valid  = 1'b0;
            head_st_tag    = TAG_W'($urandom);
            st_addr        = {$urandom, $urandom};
            mem_resp_valid = 1'($urandom);
            mem_resp_ok    = 1'($urandom);
            #2;
            vectors++;
            if ({mem_req, st_commit, st_busy, st_error} !== 4'b0) begin
                miscompares++;
                $display("FAIL stray_idle c%0d flags got %b want 0000", k,
                         {mem_req, st_commit, st_busy, st_error});
            end
            @(posedge clock);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_exhaust_nack();
        p_tag = TAG_W'($urandom); p_addr = {$urandom, $urandom}; p_data = {$urandom, $urandom};
        p_stray = 1'b1; p_extra = 12;
        for (int i = 0; i < 8; i++) begin
            p_g[i] = int'($urandom_range(2, 0)); p_kind[i] = KNack; p_r[i] = int'($urandom_range(5, 0));
        end
        run_txn();
        for (int n = 0; n < n_cyc; n++) begin
            vectors++;
            if (obs_flags[n] !== exp_flags[n]) begin
                miscompares++;
                $display("FAIL exhaust_nack c%0d flags got %b want %b", n, obs_flags[n], exp_flags[n]);
            end
            if (exp_flags[n][3] && {obs_addr[n], obs_data[n]} !== {p_addr, p_data}) begin
                miscompares++;
                $display("FAIL exhaust_nack_addr c%0d got %h/%h want %h/%h", n, obs_addr[n], obs_data[n], p_addr, p_data);
            end
        end
        do_reset();
    endtask

    task automatic test_exhaust_timeout();
        p_tag = TAG_W'($urandom); p_addr = {$urandom, $urandom}; p_data = {$urandom, $urandom};
        p_stray = 1'b1; p_extra = 12;
        for (int i = 0; i < 8; i++) begin
            p_g[i] = int'($urandom_range(2, 0)); p_kind[i] = KTo; p_r[i] = 0;
        end
        run_txn();
        for (int n = 0; n < n_cyc; n++) begin
            vectors++;
            if (obs_flags[n] !== exp_flags[n]) begin
                miscompares++;
                $display("FAIL exhaust_timeout c%0d flags got %b want %b", n, obs_flags[n], exp_flags[n]);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid_op();
        // c0: offer the store
        head_st_valid = 1'b1; head_st_tag = TAG_W'($urandom);
        st_addr = {$urandom, $urandom}; st_data = {$urandom, $urandom};
        @(posedge clock); #1;
        // c1: REQ, grant it
        idle_inputs();
        mem_gnt = 1'b1;
        #2;
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_req got %b want 1", mem_req);
        end
        @(posedge clock); #1;
        // c2: WAIT, assert reset
        mem_gnt = 1'b0;
        reset = 1'b1;
        #2;
        vectors++;
        if ({mem_req, st_busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_mid_wait req/busy got %b want 01", {mem_req, st_busy});
        end
        @(posedge clock); #1;
        // c3 onward: late ok response must be ignored
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mem_resp_valid = (k == 0) ? 1'b1 : 1'($urandom);
            mem_resp_ok    = (k == 0) ? 1'b1 : 1'($urandom);
            #2;
            vectors++;
            if ({mem_req, st_commit, st_busy, st_error, mem_addr, mem_data, st_commit_tag} !== '0)
            begin
                miscompares++;
                $display("FAIL reset_mid_after c%0d req=%b commit=%b busy=%b err=%b addr=%h data=%h tag=%h, want all 0",
                         k, mem_req, st_commit, st_busy, st_error, mem_addr, mem_data, st_commit_tag);
            end
            @(posedge clock); #1;
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            int roll;
            p_tag = TAG_W'($urandom); p_addr = {$urandom, $urandom}; p_data = {$urandom, $urandom};
            p_stray = 1'b1; p_extra = int'($urandom_range(2, 0));
            for (int i = 0; i < 8; i++) begin
                roll = int'($urandom_range(9, 0));
                p_g[i] = int'($urandom_range(4, 0));
                p_kind[i] = (roll < 6) ? KOk : ((roll < 9) ? KNack : KTo);
                p_r[i] = int'($urandom_range(15, 0));
            end
            run_txn();
            for (int n = 0; n < n_cyc; n++) begin
                vectors++;
                if (obs_flags[n] !== exp_flags[n]) begin
                    miscompares++;
                    $display("FAIL random t%0d c%0d flags got %b want %b", k, n, obs_flags[n], exp_flags[n]);
                end
                if (exp_flags[n][3] && {obs_addr[n], obs_data[n]} !== {p_addr, p_data}) begin
                    miscompares++;
                    $display("FAIL random_addr t%0d c%0d got %h/%h want %h/%h", k, n, obs_addr[n], obs_data[n], p_addr, p_data);
                end
                if (exp_flags[n][2] && obs_tag[n] !== p_tag) begin
                    miscompares++;
                    $display("FAIL random_tag t%0d c%0d got %0d want %0d", k, n, obs_tag[n], p_tag);
                end
            end
            if (err_at >= 0) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_grant_stall();
        test_nack_retry();
        test_back_to_back();
        test_stray_idle();
        test_exhaust_nack();
        test_exhaust_timeout();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
